// File: rtl/pong_pkg.sv
// Shared Pong definitions: sequencer state encodings, score limit and ball speed defaults.
// The collision controller uses the score limit and speed defaults too.
package pong_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam int unsigned SCORE_LIMIT  = 7;
  localparam int unsigned DEF_VEL_INIT = 2;
  localparam int unsigned DEF_VEL_MAX  = 8;
  localparam int unsigned DEF_Y_VEL    = 2;

endpackage

// File: rtl/pong_game_sequencer_rise_detect.sv
// Rising-edge detector for a level input synchronous to game_clk.
// The rise output is combinational, so the event is seen in the same tick the input goes high.
module rise_detect (
  input  logic game_clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge game_clk) begin
    if (!reset) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/pong_game_sequencer.sv
// Game-flow controller: idle, serve delay, rally, point pause and game over,
// driving ball speed and the ball-centre hold of the collision controller.
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_TICKS   = 60,
  parameter int unsigned PAUSE_TICKS   = 90,
  parameter int unsigned VEL_INIT      = DEF_VEL_INIT,
  parameter int unsigned VEL_MAX       = DEF_VEL_MAX,
  parameter int unsigned Y_VEL         = DEF_Y_VEL,
  parameter int unsigned HITS_PER_STEP = 4
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wall_col,
  input  logic       paddle_col,
  input  logic       lossA,
  input  logic       lossB,
  output logic [3:0] x_ball_vel,
  output logic [3:0] y_ball_vel,
  output logic       ball_center_n,
  output logic       game_over,
  output logic       winner,
  output logic       beep,
  output logic [7:0] hit_count,
  output logic [2:0] state
);

  localparam logic [15:0] SERVE_LOAD = 16'(SERVE_TICKS - 1);
  localparam logic [15:0] PAUSE_LOAD = 16'(PAUSE_TICKS - 1);
  localparam logic [3:0]  SPEED_INIT = 4'(VEL_INIT);
  localparam logic [3:0]  SPEED_MAX  = 4'(VEL_MAX);
  localparam logic [3:0]  Y_SPEED    = 4'(Y_VEL);
  localparam logic [7:0]  STEP_LAST  = 8'(HITS_PER_STEP - 1);

  logic        start_rise;
  logic        wall_rise;
  logic        paddle_rise;
  logic [15:0] timer;
  logic [3:0]  speed;
  logic [7:0]  step_cnt;
  logic        loss;

  rise_detect u_start_rise  (.game_clk(game_clk), .reset(reset), .in(start),      .rise(start_rise));
  rise_detect u_wall_rise   (.game_clk(game_clk), .reset(reset), .in(wall_col),   .rise(wall_rise));
  rise_detect u_paddle_rise (.game_clk(game_clk), .reset(reset), .in(paddle_col), .rise(paddle_rise));

  assign loss = lossA | lossB;

  always_ff @(posedge game_clk) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      speed     <= SPEED_INIT;
      step_cnt  <= '0;
      hit_count <= '0;
      beep      <= 1'b0;
      winner    <= 1'b0;
    end else begin
      beep <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state <= SERVE;
            timer <= SERVE_LOAD;
          end
        end
        SERVE: begin
          hit_count <= '0;
          speed     <= SPEED_INIT;
          step_cnt  <= '0;
          if (timer == '0) state <= PLAY;
          else             timer <= timer - 16'd1;
        end
        PLAY: begin
          // Loss beats wall beats paddle; a lower-priority event in the same tick is dropped.
          if (loss) begin
            state  <= OVER;
            winner <= lossA;
          end else if (wall_rise) begin
            state <= PAUSE;
            timer <= PAUSE_LOAD;
          end else if (paddle_rise) begin
            beep <= 1'b1;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (speed < SPEED_MAX) speed <= speed + 4'd1;
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        PAUSE: begin
          if (timer != '0) begin
            timer <= timer - 16'd1;
          end else if (loss) begin
            state  <= OVER;
            winner <= lossA;
          end else begin
            state <= SERVE;
            timer <= SERVE_LOAD;
          end
        end
        OVER: ;
        default: state <= IDLE;
      endcase
    end
  end

  // Run inputs are decoded from the registered state, so they follow it with no extra delay.
  assign x_ball_vel    = (state == PLAY) ? speed   : 4'd0;
  assign y_ball_vel    = (state == PLAY) ? Y_SPEED : 4'd0;
  assign ball_center_n = (state == PLAY);
  assign game_over     = (state == OVER);

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer: serve/pause timing, speed ramp, edge handling,
// event priority, game over and mid-rally reset.
module tb_pong_game_sequencer;

  logic game_clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, wall_col = 1'b0, paddle_col = 1'b0, lossA = 1'b0, lossB = 1'b0;

  logic [3:0] x_ball_vel, y_ball_vel;
  logic       ball_center_n, game_over, winner, beep;
  logic [7:0] hit_count;
  logic [2:0] state;

  logic [3:0] s_x_ball_vel, s_y_ball_vel;
  logic       s_ball_center_n, s_game_over, s_winner, s_beep;
  logic [7:0] s_hit_count;
  logic [2:0] s_state;

  int checks = 0;
  int failures = 0;

  always #5 game_clk = ~game_clk;

  pong_game_sequencer dut (
    .game_clk(game_clk), .reset(reset), .start(start), .wall_col(wall_col),
    .paddle_col(paddle_col), .lossA(lossA), .lossB(lossB),
    .x_ball_vel(x_ball_vel), .y_ball_vel(y_ball_vel), .ball_center_n(ball_center_n),
    .game_over(game_over), .winner(winner), .beep(beep), .hit_count(hit_count),
    .state(state)
  );

  // Same stimulus with a low speed ceiling to exercise saturation.
  pong_game_sequencer #(.VEL_MAX(3)) dut_sat (
    .game_clk(game_clk), .reset(reset), .start(start), .wall_col(wall_col),
    .paddle_col(paddle_col), .lossA(lossA), .lossB(lossB),
    .x_ball_vel(s_x_ball_vel), .y_ball_vel(s_y_ball_vel), .ball_center_n(s_ball_center_n),
    .game_over(s_game_over), .winner(s_winner), .beep(s_beep), .hit_count(s_hit_count),
    .state(s_state)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge game_clk);
    #1;
  endtask

  // Counts consecutive observed ticks in state s, starting with the current one.
  task automatic wait_state(input logic [2:0] s, input int max_ticks, output int n);
    n = 0;
    while (state == s && n < max_ticks) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n, beeps, bad;

    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_xvel", x_ball_vel, 0);
    check("rst_yvel", y_ball_vel, 0);
    check("rst_bcn", ball_center_n, 0);
    check("rst_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_beep", beep, 0);
    check("rst_hits", hit_count, 0);
    reset = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state != 0 || x_ball_vel != 0 || ball_center_n != 0 || beep != 0) bad++;
    end
    check("idle_hold", bad, 0);

    start = 1'b1; tick(); start = 1'b0;
    wait_state(3'd1, 200, n);
    check("serve_len", n, 60);
    check("play_state", state, 2);
    check("play_xvel", x_ball_vel, 2);
    check("play_yvel", y_ball_vel, 2);
    check("play_bcn", ball_center_n, 1);

    beeps = 0;
    for (int h = 1; h <= 9; h++) begin
      paddle_col = 1'b1;
      repeat (8) begin tick(); beeps += int'(beep); end
      paddle_col = 1'b0;
      repeat (4) begin tick(); beeps += int'(beep); end
      if (h == 4) begin
        check("ramp_h4_x", x_ball_vel, 3);
        check("sat_h4_x", s_x_ball_vel, 3);
      end
      if (h == 8) begin
        check("ramp_h8_x", x_ball_vel, 4);
        check("sat_h8_x", s_x_ball_vel, 3);
      end
    end
    check("hits9", hit_count, 9);
    check("beeps9", beeps, 9);
    check("sat_hits9", s_hit_count, 9);

    beeps = 0;
    paddle_col = 1'b1;
    repeat (20) begin tick(); beeps += int'(beep); end
    paddle_col = 1'b0;
    tick(); beeps += int'(beep);
    check("held_hits", hit_count, 10);
    check("held_beeps", beeps, 1);

    wall_col = 1'b1; paddle_col = 1'b1;
    tick();
    wall_col = 1'b0; paddle_col = 1'b0;
    check("wp_state", state, 3);
    check("wp_hits", hit_count, 10);
    check("wp_beep", beep, 0);
    check("wp_xvel", x_ball_vel, 0);

    n = 0; bad = 0;
    while (state == 3'd3 && n < 200) begin
      n++;
      if (x_ball_vel != 0 || y_ball_vel != 0 || ball_center_n != 0) bad++;
      tick();
    end
    check("pause_len", n, 90);
    check("pause_vel", bad, 0);
    check("pause_next", state, 1);
    wait_state(3'd1, 200, n);
    check("serve2_len", n, 60);
    check("play2_state", state, 2);
    check("play2_xvel", x_ball_vel, 2);
    check("play2_hits", hit_count, 0);

    // Step counter must restart: three more hits stay below the next speed step.
    for (int h = 0; h < 3; h++) begin
      paddle_col = 1'b1; repeat (2) tick();
      paddle_col = 1'b0; repeat (2) tick();
    end
    check("step_hits", hit_count, 3);
    check("step_xvel", x_ball_vel, 2);

    lossA = 1'b1; wall_col = 1'b1;
    tick();
    wall_col = 1'b0;
    check("lossA_state", state, 4);
    check("lossA_over", game_over, 1);
    check("lossA_winner", winner, 1);
    check("lossA_xvel", x_ball_vel, 0);
    check("lossA_bcn", ball_center_n, 0);
    repeat (3) begin start = 1'b1; tick(); start = 1'b0; tick(); end
    lossA = 1'b0; tick();
    check("over_state", state, 4);
    check("over_winner", winner, 1);
    check("over_flag", game_over, 1);

    reset = 1'b0; tick(); reset = 1'b1;
    check("over_rst_state", state, 0);
    start = 1'b1; tick(); start = 1'b0;
    wait_state(3'd1, 200, n);
    check("mid_play", state, 2);
    paddle_col = 1'b1; tick();
    check("mid_beep", beep, 1);
    reset = 1'b0; tick();
    check("mid_rst_state", state, 0);
    check("mid_rst_xvel", x_ball_vel, 0);
    check("mid_rst_yvel", y_ball_vel, 0);
    check("mid_rst_bcn", ball_center_n, 0);
    check("mid_rst_hits", hit_count, 0);
    check("mid_rst_beep", beep, 0);
    check("mid_rst_over", game_over, 0);
    paddle_col = 1'b0; reset = 1'b1; tick();

    start = 1'b1; tick(); start = 1'b0;
    wait_state(3'd1, 200, n);
    lossB = 1'b1; tick();
    check("lossB_state", state, 4);
    check("lossB_winner", winner, 0);
    lossB = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
Game-flow controller that consumes the ball collision controller's status outputs (wall_col, paddle_col, lossA, lossB) and produces its run inputs: ball velocity magnitudes and the ball-centre hold. It sequences idle, serve delay, rally, point pause and game over, and ramps ball speed with the rally length. It sits beside the collision controller in the Pong top level and runs on the same game tick.

Parameters:
SERVE_TICKS, 60, game ticks of serve delay before the ball moves (>=1)
PAUSE_TICKS, 90, game ticks of pause after a point is scored (>=1)
VEL_INIT, 2, x speed at the start of each rally
VEL_MAX, 8, x speed saturation value (<=15)
Y_VEL, 2, constant y speed during a rally
HITS_PER_STEP, 4, paddle hits per +1 x speed step (>=1)

Ports:
game_clk  in  1  game tick clock
reset  in  1  synchronous, active-low
start  in  1  player start button, level, synchronous to game_clk
wall_col  in  1  collision controller wall status (level, multi-tick)
paddle_col  in  1  collision controller paddle status (level, multi-tick)
lossA  in  1  high when player A has lost (score reached 7)
lossB  in  1  high when player B has lost
x_ball_vel  out  4  x speed to collision controller
y_ball_vel  out  4  y speed to collision controller
ball_center_n  out  1  active-low hold-ball-centred, drives collision controller reset
game_over  out  1  high in OVER
winner  out  1  0 = player A won, 1 = player B won; valid when game_over=1
beep  out  1  one-tick pulse per counted paddle hit
hit_count  out  8  paddle hits in the current rally, saturates at 255
state  out  3  current state encoding for debug/display

Behaviour:
- reset is checked on every game_clk edge. reset=0 gives: state=IDLE, x/y_ball_vel=0, ball_center_n=0, game_over=0, winner=0, beep=0, hit_count=0, timer=0, speed=VEL_INIT, step counter=0, edge registers=0. Reset overrides all state, including mid-rally.
- Edge detect: wall_col, paddle_col and start are each registered once. rise = in & ~in_q. Only rises are events, because the status inputs stay high for several ticks. Events are acted on in the cycle the rise is seen, and outputs update on the next edge (latency 1 tick).
- State encodings: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4.
- IDLE: vel=0, ball_center_n=0. A start rise moves to SERVE and loads timer=SERVE_TICKS-1.
- SERVE: vel=0, ball_center_n=0, hit_count=0, speed=VEL_INIT, step counter=0. Timer decrements each tick. When timer==0, move to PLAY.
- PLAY: ball_center_n=1, x_ball_vel=speed, y_ball_vel=Y_VEL.
  - Paddle rise: hit_count++ (saturating), beep=1 for one tick, step counter++. When the step counter reaches HITS_PER_STEP, speed=min(speed+1, VEL_MAX) and the step counter clears.
  - Wall rise: move to PAUSE, load timer=PAUSE_TICKS-1, vel=0.
  - lossA or lossB high: move to OVER. Loss has priority over wall rise, and wall rise has priority over paddle rise. A lower-priority event in the same tick is dropped (no hit count, no beep).
- PAUSE: vel=0, ball_center_n=0, hit_count is held for display. Timer counts down. At 0, re-check loss: loss high goes to OVER, otherwise go to SERVE with timer=SERVE_TICKS-1.
- OVER: game_over=1, vel=0, ball_center_n=0. winner=1 if lossA, else 0 (lossB). If both are high, lossA wins (winner=1). winner is latched on entry. OVER is terminal until reset; start is ignored.
- beep is 0 in every state except the single tick that follows a counted paddle rise.
- Unused state encodings (5-7) go to IDLE on the next tick.

Decomposition:
- Shared package pong_pkg: state encodings (IDLE..OVER), the 3-bit state type, score-limit constant 7, default VEL_INIT/VEL_MAX/Y_VEL. The collision controller also uses the score limit and ball defaults.
- One natural sub-module: rise_detect (1-bit register plus AND-NOT, synchronous active-low reset), instantiated three times for start, wall_col and paddle_col.

Test Plan:
- Reset then hold start=0 for 100 ticks -> state=0, vel=0, ball_center_n=0, beep never 1.
- Start rise with SERVE_TICKS=60 -> state=1 for exactly 60 ticks, then state=2, x_ball_vel=2, y_ball_vel=2, ball_center_n=1.
- In PLAY, 9 paddle rises (paddle_col high 8 ticks each) -> hit_count=9, 9 single-tick beeps, x_ball_vel 2->3 after hit 4 and 3->4 after hit 8. With VEL_MAX=3, x_ball_vel stays 3.
- In PLAY, paddle_col held high 20 ticks -> exactly one hit counted. Wall and paddle rise on the same tick -> state=3, hit_count unchanged, no beep.
- Wall rise with PAUSE_TICKS=90 -> vel=0 for 90 ticks, then SERVE. On return to PLAY, speed is back at 2 and hit_count=0.
- lossA raised together with a wall rise -> state=4, game_over=1, winner=1. Further start rises leave it unchanged. Reset mid-rally returns to state=0 with all outputs at reset values.
